// File: rtl/cpu_pkg.sv
// Shared definitions for the PC/fetch path: FSM encoding, reset PC and instruction field bounds.
package cpu_pkg;
    localparam int PC_W        = 30;
    localparam int INSTR_W     = 32;
    localparam int TARADDR_MSB = 25;
    localparam int IMM_MSB     = 15;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0000_0C00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;
endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: imem request/ack, decode valid/ready and the npc exchange.
interface pc_fetch_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]        newpc;
    logic [PC_W-1:0]        pcout;
    logic                   imem_req;
    logic [PC_W-1:0]        imem_addr;
    logic                   imem_ack;
    logic [INSTR_W-1:0]     imem_rdata;
    logic [INSTR_W-1:0]     instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [TARADDR_MSB:0]   taraddr;
    logic [IMM_MSB:0]       imm;
    logic [31:0]            retire_cnt;

    modport master (
        input  newpc, imem_ack, imem_rdata, instr_ready,
        output pcout, imem_req, imem_addr, instr, instr_valid, taraddr, imm, retire_cnt
    );

    modport slave (
        output newpc, imem_ack, imem_rdata, instr_ready,
        input  pcout, imem_req, imem_addr, instr, instr_valid, taraddr, imm, retire_cnt
    );
endinterface

// File: rtl/pc_reg.sv
// Word-PC register: async reset to a fixed value, loads only when enabled.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VAL = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_i,
    input  logic [PC_W-1:0] d_i,
    output logic [PC_W-1:0] q_o
);
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pc_q <= RESET_VAL;
        else if (ld_i) pc_q <= d_i;
    end

    assign q_o = pc_q;
endmodule

// File: rtl/pc_fetch.sv
// PC + instruction fetch unit: alternates imem fetch and decode issue, retiring into npc's newpc.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pc_fetch_if.master  bus
);
    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 vld_q, vld_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [31:0]          retire_cnt_q;
    logic                 instr_ld;
    logic                 retire;
    logic [PC_W-1:0]      pc_q;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vld_d    = vld_q;
        instr_ld = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_ld = 1'b1;
                    req_d    = 1'b0;
                    vld_d    = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    retire  = 1'b1;
                    vld_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            vld_q        <= 1'b0;
            instr_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            if (instr_ld) instr_q      <= bus.imem_rdata;
            if (retire)   retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    // newpc is only trusted at retire; npc has had the whole ISSUE stall to settle
    pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .ld_i (retire),
        .d_i  (bus.newpc),
        .q_o  (pc_q)
    );

    assign bus.pcout       = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = vld_q;
    assign bus.taraddr     = instr_q[TARADDR_MSB:0];
    assign bus.imm         = instr_q[IMM_MSB:0];
    assign bus.retire_cnt  = retire_cnt_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: inputs driven and outputs sampled on the falling edge.
module tb_pc_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(30'h0000_0C00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.newpc       = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        step(); step();

        chk("rst_req",   32'(bus.imem_req),    32'd0);
        chk("rst_vld",   32'(bus.instr_valid), 32'd0);
        chk("rst_pc",    32'(bus.pcout),       32'h0C00);
        chk("rst_instr", bus.instr,            32'h0);
        chk("rst_cnt",   bus.retire_cnt,       32'd0);

        // release: req rises on the first edge
        rst = 1'b0;
        step();
        chk("rel_req",  32'(bus.imem_req),  32'd1);
        chk("rel_addr", 32'(bus.imem_addr), 32'h0C00);

        // zero-wait fetch and immediate retire
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        bus.newpc       = 30'h0C01;
        bus.instr_ready = 1'b1;
        step();
        chk("zw_vld",     32'(bus.instr_valid), 32'd1);
        chk("zw_req",     32'(bus.imem_req),    32'd0);
        chk("zw_imm",     32'(bus.imm),         32'h5678);
        chk("zw_taraddr", 32'(bus.taraddr),     32'h0234_5678);
        chk("zw_pc_hold", 32'(bus.pcout),       32'h0C00);
        bus.imem_ack = 1'b0;
        step();
        chk("zw_ret_pc",  32'(bus.pcout),       32'h0C01);
        chk("zw_ret_cnt", bus.retire_cnt,       32'd1);
        chk("zw_ret_req", 32'(bus.imem_req),    32'd1);
        chk("zw_ret_vld", 32'(bus.instr_valid), 32'd0);

        // memory wait: ack withheld 3 cycles
        bus.instr_ready = 1'b0;
        bus.imem_rdata  = 32'hAABB_CCDD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mw_req",  32'(bus.imem_req),    32'd1);
            chk("mw_addr", 32'(bus.imem_addr),   32'h0C01);
            chk("mw_vld",  32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ack = 1'b1;
        step();
        chk("mw_ack_vld",   32'(bus.instr_valid), 32'd1);
        chk("mw_ack_instr", bus.instr,            32'hAABB_CCDD);
        bus.imem_ack = 1'b0;

        // spurious ack during ISSUE
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h5555_AAAA;
        step();
        bus.imem_ack = 1'b0;
        chk("sp_ack_instr", bus.instr,            32'hAABB_CCDD);
        chk("sp_ack_vld",   32'(bus.instr_valid), 32'd1);
        chk("sp_ack_req",   32'(bus.imem_req),    32'd0);

        // execute stall with toggling newpc
        for (int i = 0; i < 5; i++) begin
            bus.newpc = (i % 2 == 0) ? 30'h0000_1111 : 30'h0000_2222;
            step();
            chk("st_pc",    32'(bus.pcout),       32'h0C01);
            chk("st_instr", bus.instr,            32'hAABB_CCDD);
            chk("st_vld",   32'(bus.instr_valid), 32'd1);
        end
        bus.newpc       = 30'h0000_0ABC;
        bus.instr_ready = 1'b1;
        step();
        chk("st_ret_pc",  32'(bus.pcout),    32'h0ABC);
        chk("st_ret_cnt", bus.retire_cnt,    32'd2);
        chk("st_ret_req", 32'(bus.imem_req), 32'd1);

        // spurious ready during FETCH (ready still high from the retire)
        step();
        bus.instr_ready = 1'b0;
        chk("sp_rdy_cnt", bus.retire_cnt,       32'd2);
        chk("sp_rdy_pc",  32'(bus.pcout),       32'h0ABC);
        chk("sp_rdy_req", 32'(bus.imem_req),    32'd1);
        chk("sp_rdy_vld", 32'(bus.instr_valid), 32'd0);

        // wrap: go to 3FFF_FFFF then to 0
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; bus.newpc = 30'h3FFF_FFFF;
        step();
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        step();
        chk("wr_pc_max", 32'(bus.pcout), 32'h3FFF_FFFF);
        bus.instr_ready = 1'b0; bus.imem_ack = 1'b1; bus.newpc = 30'h0;
        step();
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("wr_pc_zero", 32'(bus.pcout),     32'h0);
        chk("wr_addr",    32'(bus.imem_addr), 32'h0);
        chk("wr_cnt",     bus.retire_cnt,     32'd4);

        // reset mid-FETCH with a pending ack
        chk("mr_pre_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1;
        rst = 1'b1;
        #1;
        chk("mr_req",   32'(bus.imem_req),    32'd0);
        chk("mr_vld",   32'(bus.instr_valid), 32'd0);
        chk("mr_pc",    32'(bus.pcout),       32'h0C00);
        chk("mr_cnt",   bus.retire_cnt,       32'd0);
        chk("mr_instr", bus.instr,            32'h0);
        step();
        chk("mr_hold_vld", 32'(bus.instr_valid), 32'd0);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        chk("mr_rel_req",  32'(bus.imem_req),    32'd1);
        chk("mr_rel_addr", 32'(bus.imem_addr),   32'h0C00);
        chk("mr_rel_vld",  32'(bus.instr_valid), 32'd0);

        // reset during ISSUE drops valid at once
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0F0F_0F0F;
        step();
        bus.imem_ack = 1'b0;
        chk("ri_vld_pre", 32'(bus.instr_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("ri_vld", 32'(bus.instr_valid), 32'd0);
        chk("ri_req", 32'(bus.imem_req),    32'd0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch unit: the other end of the `npc` interface. It owns the 30-bit word PC and drives `pcout`, plus the `imm` and `taraddr` fields of the current instruction, into `npc`. It consumes `npc`'s combinational `newpc` when the current instruction retires. It sits between instruction memory (request/acknowledge handshake) and the decode/execute stage (valid/ready handshake).

## Interface
- `RESET_PC`, default 30'h0000_0C00 (byte address 0x3000): word PC loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `newpc`  in  30  next word PC from `npc`; sampled only at retire.
- `pcout`  out  30  current word PC, to `npc` and to `imem_addr`.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  30  word address; equals `pcout`.
- `imem_ack`  in  1  instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction to decode.
- `instr_valid`  out  1  `instr` valid; registered.
- `instr_ready`  in  1  execute done; the instruction may retire.
- `taraddr`  out  26  `instr[25:0]`, to `npc`.
- `imm`  out  16  `instr[15:0]`, to `npc`.
- `retire_cnt`  out  32  number of retired instructions.

## Operation
- FSM states:
  - IDLE: held by reset.
  - FETCH: `imem_req`=1.
  - ISSUE: `instr_valid`=1.
- IDLE -> FETCH on the first edge with `rst` low.
- FETCH, `imem_ack`=1 at an edge:
  - `instr` <= `imem_rdata`.
  - `imem_req` <= 0, `instr_valid` <= 1.
  - Go to ISSUE.
- FETCH, `imem_ack`=0: stay in FETCH; `imem_req` and `imem_addr` held stable.
- ISSUE, `instr_ready`=1 at an edge:
  - `pcout` <= `newpc`.
  - `retire_cnt` <= `retire_cnt`+1.
  - `instr_valid` <= 0, `imem_req` <= 1.
  - Go to FETCH.
- ISSUE, `instr_ready`=0: hold. `instr`, `pcout`, `taraddr` and `imm` stay stable so `newpc` settles.
- `imem_ack` outside FETCH is ignored. `instr_ready` outside ISSUE is ignored.
- PC wrap-around: `newpc` is loaded verbatim, e.g. 30'h3FFF_FFFF to 30'h0. No arithmetic is done in this block.
- `retire_cnt` wraps modulo 2^32.
- `taraddr`, `imm` and `imem_addr` are combinational slices/copies of registers; there is no extra latency.

## Timing
- Reset values (asynchronous, immediate):
  - `pcout`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `retire_cnt`=0.
  - State=IDLE.
- Reset mid-operation (any state):
  - `imem_req` and `instr_valid` drop in the same cycle.
  - A pending ack is discarded.
  - The PC returns to `RESET_PC`.
  - The first request after release fetches `RESET_PC`.
- `imem_req` rises one edge after `rst` deasserts.
- Fetch latency: `instr_valid` rises on the edge that samples `imem_ack`.
- Minimum throughput is 2 cycles per instruction: ack in the first FETCH cycle, ready in the first ISSUE cycle.
- `imem_ack` may be high in the same cycle `imem_req` first rises; it is accepted.
- `imem_req` and `instr_valid` are never high together.

## Structure
- Shared package `cpu_pkg`:
  - state enum (IDLE/FETCH/ISSUE, 2-bit).
  - `RESET_PC` default.
  - instruction field bounds: TARADDR 25:0, IMM 15:0, PC width 30.
- One sub-module, `pc_reg`:
  - 30-bit register with async reset to a parameter value and a load enable.
  - Instantiated for `pcout`; load enable = retire.
- Top level holds the FSM, the instruction latch and the retire counter.

## Test plan
- Reset: assert `rst` mid-FETCH with `imem_req`=1 -> `imem_req`=0 and `pcout`=30'h0C00 immediately. After release, `imem_req`=1 on the first edge with `imem_addr`=30'h0C00.
- Zero-wait fetch: ack same cycle as req with `imem_rdata`=32'h1234_5678, `newpc`=30'h0C01, ready immediately:
  - `instr_valid` rises next edge, with `imm`=16'h5678 and `taraddr`=26'h234_5678.
  - After retire, `pcout`=30'h0C01 and `retire_cnt`=1.
- Memory wait: ack delayed 3 cycles -> `imem_req` and `imem_addr` stable for all 4 cycles; no `instr_valid` until the ack edge.
- Execute stall: ready held low 5 cycles while `newpc` toggles -> `pcout` and `instr` unchanged. On the ready edge, `pcout` takes the `newpc` value present at that edge.
- Wrap: `pcout`=30'h3FFF_FFFF, `newpc`=30'h0 -> after retire, `pcout`=0 and `imem_addr`=0.
- Spurious handshakes: ack pulse during ISSUE and ready pulse during FETCH -> no state change, `instr` and `retire_cnt` unchanged.
